// File: rtl/dma_multi_pkg.sv
// dma_multi_pkg: shared definitions for the multi-channel DMA controller.
//   state_t      controller FSM states
//   OP_WR/OP_RD  header opcodes
//   hdr_*        header field offsets derived from the configured widths
package dma_multi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    REQ   = 3'd2,
    HDR   = 3'd3,
    WDATA = 3'd4,
    RDATA = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [7:0]  OP_WR = 8'h03;
  localparam logic [7:0]  OP_RD = 8'h01;
  localparam int unsigned OP_W  = 8;

  // Header layout, LSB first: local_addr, host_addr, len, opcode, zero pad.
  function automatic int unsigned hdr_haddr_lsb(input int unsigned laddr_w);
    return laddr_w;
  endfunction

  function automatic int unsigned hdr_len_lsb(input int unsigned laddr_w,
                                              input int unsigned haddr_w);
    return laddr_w + haddr_w;
  endfunction

  function automatic int unsigned hdr_op_lsb(input int unsigned laddr_w,
                                             input int unsigned haddr_w,
                                             input int unsigned len_w);
    return laddr_w + haddr_w + len_w;
  endfunction

  function automatic int unsigned hdr_bits(input int unsigned laddr_w,
                                           input int unsigned haddr_w,
                                           input int unsigned len_w);
    return OP_W + laddr_w + haddr_w + len_w;
  endfunction

endpackage

// File: rtl/dma_multi_ctrl_if.sv
// dma_multi_ctrl_if: link between the DMA controller and the DMA path.
//   dma_req/dma_resp             path request / grant
//   dma_wvalid/wdata/wready      header + write payload stream (controller -> path)
//   dma_rvalid/rdata/rready      read payload stream (path -> controller)
// master = controller side, slave = path side.
interface dma_multi_ctrl_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              dma_req;
  logic              dma_resp;
  logic              dma_wvalid;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wready;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rready;

  modport master (
    output dma_req, dma_wvalid, dma_wdata, dma_rready,
    input  dma_resp, dma_wready, dma_rvalid, dma_rdata
  );

  modport slave (
    input  dma_req, dma_wvalid, dma_wdata, dma_rready,
    output dma_resp, dma_wready, dma_rvalid, dma_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req    request vector
//   i_ptr    highest-priority index this round
//   o_grant  one-hot grant (first request at or after i_ptr, wrapping)
//   o_idx    binary index of the grant
//   o_valid  at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_idx,
  output logic                      o_valid
);
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_cand = IDX_W'((32'(i_ptr) + k) % NUM_CH);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_multi_ctrl.sv
// dma_multi_ctrl: round-robin multi-channel DMA controller, one transfer in
// flight. Sends one descriptor header beat, then streams LEN write beats from
// the granted channel or routes LEN read beats back to it.
//   clk, reset               clock; asynchronous active-high reset
//   ch_req/ch_rwn            per-channel request level / 1=read
//   ch_host_addr/local/len   packed per-channel descriptors
//   ch_grant                 one-hot owner of the current transfer
//   ch_wvalid/wdata/wready   per-channel write payload
//   ch_rvalid/ch_rdata       read beats to the owner (no backpressure)
//   ch_done/ch_err           one-cycle completion / timeout pulses
//   dma                      path interface (master modport)
// Optional: DMA_MULTI_CTRL_TIMEOUT_EN adds TIMEOUT_CYC and a stall watchdog.
module dma_multi_ctrl
  import dma_multi_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned HADDR_W = 40,
  parameter int unsigned LADDR_W = 14,
  parameter int unsigned LEN_W   = 16
`ifdef DMA_MULTI_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_rwn,
  input  logic [NUM_CH*HADDR_W-1:0] ch_host_addr,
  input  logic [NUM_CH*LADDR_W-1:0] ch_local_addr,
  input  logic [NUM_CH*LEN_W-1:0]   ch_len,
  output logic [NUM_CH-1:0]         ch_grant,
  input  logic [NUM_CH-1:0]         ch_wvalid,
  input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]         ch_wready,
  output logic [NUM_CH-1:0]         ch_rvalid,
  output logic [DATA_W-1:0]         ch_rdata,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_err,
  dma_multi_ctrl_if.master          dma
);
  localparam int unsigned IDX_W     = $clog2(NUM_CH);
  localparam int unsigned HADDR_LSB = hdr_haddr_lsb(LADDR_W);
  localparam int unsigned LEN_LSB   = hdr_len_lsb(LADDR_W, HADDR_W);
  localparam int unsigned OP_LSB    = hdr_op_lsb(LADDR_W, HADDR_W, LEN_W);

  if (hdr_bits(LADDR_W, HADDR_W, LEN_W) > DATA_W) begin : g_bad_width
    $error("dma_multi_ctrl: header does not fit in DATA_W");
  end
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_nch
    $error("dma_multi_ctrl: NUM_CH must be 2..8");
  end

  // Per-channel views of the packed descriptor/payload buses.
  logic [HADDR_W-1:0] w_ch_haddr [NUM_CH];
  logic [LADDR_W-1:0] w_ch_laddr [NUM_CH];
  logic [LEN_W-1:0]   w_ch_len   [NUM_CH];
  logic [DATA_W-1:0]  w_ch_wdata [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_ch_haddr[g] = ch_host_addr[g*HADDR_W +: HADDR_W];
    assign w_ch_laddr[g] = ch_local_addr[g*LADDR_W +: LADDR_W];
    assign w_ch_len[g]   = ch_len[g*LEN_W +: LEN_W];
    assign w_ch_wdata[g] = ch_wdata[g*DATA_W +: DATA_W];
  end

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_ptr, r_gidx, w_arb_idx;
  logic [NUM_CH-1:0]  r_gnt, w_arb_gnt;
  logic               w_arb_valid;
  logic               r_rwn;
  logic [HADDR_W-1:0] r_haddr;
  logic [LADDR_W-1:0] r_laddr;
  logic [LEN_W-1:0]   r_len, r_cnt;
  logic [DATA_W-1:0]  w_hdr;
  logic               w_hdr_hs, w_wbeat, w_rbeat, w_last, w_to, w_err;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req   (ch_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_hdr_hs = (r_state == HDR) && dma.dma_wready;
  assign w_wbeat  = (r_state == WDATA) && ch_wvalid[r_gidx] && dma.dma_wready;
  assign w_rbeat  = (r_state == RDATA) && dma.dma_rvalid;
  assign w_last   = (r_cnt == r_len - LEN_W'(1));

  always_comb begin
    w_hdr                         = '0;
    w_hdr[LADDR_W-1:0]            = r_laddr;
    w_hdr[HADDR_LSB +: HADDR_W]   = r_haddr;
    w_hdr[LEN_LSB +: LEN_W]       = r_len;
    w_hdr[OP_LSB +: OP_W]         = r_rwn ? OP_RD : OP_WR;
  end

`ifdef DMA_MULTI_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err, w_timed, w_prog;

  assign w_timed = (r_state == REQ) || (r_state == HDR) ||
                   (r_state == WDATA) || (r_state == RDATA);
  // Granting the path counts as progress so it wins over a same-cycle expiry.
  assign w_prog  = w_hdr_hs || w_wbeat || w_rbeat ||
                   ((r_state == REQ) && dma.dma_resp);
  assign w_to    = w_timed && !w_prog && (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign w_err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_next != r_state || w_prog) r_wd <= '0;
      else if (w_timed)                r_wd <= r_wd + 1'b1;
      if (w_to)                        r_err <= 1'b1;
      else if (r_state == DONE)        r_err <= 1'b0;
    end
  end
`else
  assign w_to  = 1'b0;
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (|ch_req) w_next = ARB;
      // Requests may vanish between IDLE and ARB; fall back rather than grant nobody.
      ARB:   w_next = w_arb_valid ? REQ : IDLE;
      REQ:   if (dma.dma_resp) w_next = HDR;
      HDR:   if (w_hdr_hs) w_next = (r_len == '0) ? DONE : (r_rwn ? RDATA : WDATA);
      WDATA: if (w_wbeat && w_last) w_next = DONE;
      RDATA: if (w_rbeat && w_last) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_to) w_next = DONE;
  end

  always_comb begin
    ch_grant       = '0;
    ch_wready      = '0;
    ch_rvalid      = '0;
    ch_rdata       = '0;
    ch_done        = '0;
    ch_err         = '0;
    dma.dma_req    = 1'b0;
    dma.dma_wvalid = 1'b0;
    dma.dma_wdata  = '0;
    dma.dma_rready = 1'b0;
    case (r_state)
      ARB: ch_grant = w_arb_gnt;
      REQ: begin
        ch_grant    = r_gnt;
        dma.dma_req = 1'b1;
      end
      HDR: begin
        ch_grant       = r_gnt;
        dma.dma_wvalid = 1'b1;
        dma.dma_wdata  = w_hdr;
      end
      WDATA: begin
        ch_grant          = r_gnt;
        dma.dma_wvalid    = ch_wvalid[r_gidx];
        dma.dma_wdata     = w_ch_wdata[r_gidx];
        ch_wready[r_gidx] = dma.dma_wready;
      end
      RDATA: begin
        ch_grant          = r_gnt;
        dma.dma_rready    = 1'b1;
        ch_rvalid[r_gidx] = dma.dma_rvalid;
        ch_rdata          = dma.dma_rdata;
      end
      DONE: begin
        if (w_err) ch_err  = r_gnt;
        else       ch_done = r_gnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_gnt   <= '0;
      r_rwn   <= 1'b0;
      r_haddr <= '0;
      r_laddr <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == ARB && w_arb_valid) begin
        r_gidx  <= w_arb_idx;
        r_gnt   <= w_arb_gnt;
        r_rwn   <= ch_rwn[w_arb_idx];
        r_haddr <= w_ch_haddr[w_arb_idx];
        r_laddr <= w_ch_laddr[w_arb_idx];
        r_len   <= w_ch_len[w_arb_idx];
        r_ptr   <= (w_arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_arb_idx + 1'b1;
      end
      if (r_state == HDR)          r_cnt <= '0;
      else if (w_wbeat || w_rbeat) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_multi_ctrl.sv
// tb_dma_multi_ctrl: directed self-checking bench for dma_multi_ctrl.
// Inputs are driven 1ns after the rising edge; outputs sampled on the falling edge.
module tb_dma_multi_ctrl;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned HADDR_W = 40;
  localparam int unsigned LADDR_W = 14;
  localparam int unsigned LEN_W   = 16;

  typedef logic [DATA_W-1:0] w_t;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0]         ch_req, ch_rwn, ch_grant, ch_wvalid, ch_wready;
  logic [NUM_CH-1:0]         ch_rvalid, ch_done, ch_err;
  logic [NUM_CH*HADDR_W-1:0] ch_host_addr;
  logic [NUM_CH*LADDR_W-1:0] ch_local_addr;
  logic [NUM_CH*LEN_W-1:0]   ch_len;
  logic [NUM_CH*DATA_W-1:0]  ch_wdata;
  logic [DATA_W-1:0]         ch_rdata;

  logic [HADDR_W-1:0] t_ha [NUM_CH];
  logic [LADDR_W-1:0] t_la [NUM_CH];
  logic [LEN_W-1:0]   t_len[NUM_CH];
  logic [DATA_W-1:0]  t_wd [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_host_addr[g*HADDR_W +: HADDR_W] = t_ha[g];
    assign ch_local_addr[g*LADDR_W +: LADDR_W] = t_la[g];
    assign ch_len[g*LEN_W +: LEN_W]           = t_len[g];
    assign ch_wdata[g*DATA_W +: DATA_W]       = t_wd[g];
  end

  dma_multi_ctrl_if #(.DATA_W(DATA_W)) dma_bus ();

  dma_multi_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HADDR_W(HADDR_W),
    .LADDR_W(LADDR_W), .LEN_W(LEN_W)
`ifdef DMA_MULTI_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_rwn(ch_rwn),
    .ch_host_addr(ch_host_addr), .ch_local_addr(ch_local_addr), .ch_len(ch_len),
    .ch_grant(ch_grant),
    .ch_wvalid(ch_wvalid), .ch_wdata(ch_wdata), .ch_wready(ch_wready),
    .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .ch_done(ch_done), .ch_err(ch_err),
    .dma(dma_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  function automatic w_t hdr(input logic [7:0] op, input logic [15:0] len,
                             input logic [39:0] ha, input logic [13:0] la);
    return {50'h0, op, len, ha, la};
  endfunction

  function automatic w_t beat(input int ch, input int k);
    return {32'hC0DE_0000 + 32'(ch), 32'(k), 64'hFEED_FACE_0000_0000 + 64'(ch * 16 + k)};
  endfunction

  task automatic set_desc(input logic [1:0] ch, input logic rwn, input logic [39:0] ha,
                          input logic [13:0] la, input logic [15:0] len);
    ch_rwn[ch] = rwn;
    t_ha[ch]   = ha;
    t_la[ch]   = la;
    t_len[ch]  = len;
  endtask

  function automatic w_t outs_or();
    return w_t'({ch_grant, ch_wready, ch_rvalid, ch_done, ch_err, dma_bus.dma_req,
                 dma_bus.dma_wvalid, dma_bus.dma_rready, |ch_rdata, |dma_bus.dma_wdata});
  endfunction

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [6:0]  pat;
    logic [1:0]  e;
    logic [NUM_CH-1:0] dseen;
    logic        wv, wr;
    int          k, cyc;

    reset = 1'b1;
    ch_req = '0; ch_rwn = '0; ch_wvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      t_ha[i] = '0; t_la[i] = '0; t_len[i] = '0; t_wd[i] = '0;
    end
    dma_bus.dma_resp = 1'b0; dma_bus.dma_wready = 1'b0;
    dma_bus.dma_rvalid = 1'b0; dma_bus.dma_rdata = '0;
    nxt();
    obs(); check("reset_outs", outs_or(), '0);
    nxt(); reset = 1'b0;

    // Single write: ch1, len 3, path grant in the third REQ cycle.
    set_desc(2'd1, 1'b0, 40'h12_3456_7890, 14'h0040, 16'd3);
    ch_req = 4'b0010;
    obs(); check("t1_idle_grant", w_t'(ch_grant), '0); nxt();
    obs(); check("t1_arb_grant", w_t'(ch_grant), w_t'(4'b0010)); nxt();
    ch_req = '0;
    set_desc(2'd1, 1'b1, 40'hFF_FFFF_FFFF, 14'h3FFF, 16'd9);
    obs(); check("t1_req", w_t'(dma_bus.dma_req), w_t'(1'b1)); nxt();
    obs(); nxt();
    dma_bus.dma_resp = 1'b1;
    obs(); check("t1_req_c3", w_t'(dma_bus.dma_req), w_t'(1'b1)); nxt();
    dma_bus.dma_resp = 1'b0; dma_bus.dma_wready = 1'b1;
    obs();
    check("t1_hdr_valid", w_t'(dma_bus.dma_wvalid), w_t'(1'b1));
    check("t1_hdr", dma_bus.dma_wdata, hdr(8'h03, 16'd3, 40'h12_3456_7890, 14'h0040));
    check("t1_req_drop", w_t'(dma_bus.dma_req), '0);
    nxt();
    for (int b = 0; b < 3; b++) begin
      t_wd[1] = beat(1, b); ch_wvalid = 4'b0010;
      obs();
      check("t1_wvalid", w_t'(dma_bus.dma_wvalid), w_t'(1'b1));
      check("t1_beat", dma_bus.dma_wdata, beat(1, b));
      check("t1_wready", w_t'(ch_wready), w_t'(4'b0010));
      nxt();
    end
    ch_wvalid = '0;
    obs();
    check("t1_done", w_t'(ch_done), w_t'(4'b0010));
    check("t1_done_grant", w_t'(ch_grant), '0);
    nxt();
    obs(); check("t1_idle_done", w_t'(ch_done), '0); nxt();

    // Read: ch0, len 4, header stalled once, returned beats with gaps.
    set_desc(2'd0, 1'b1, 40'h00_0000_1000, 14'h0123, 16'd4);
    ch_req = 4'b0001;
    obs(); nxt();
    obs(); check("t2_arb_grant", w_t'(ch_grant), w_t'(4'b0001)); nxt();
    ch_req = '0; dma_bus.dma_resp = 1'b1;
    obs(); nxt();
    dma_bus.dma_resp = 1'b0; dma_bus.dma_wready = 1'b0;
    obs(); check("t2_hdr_stall", w_t'(dma_bus.dma_wvalid), w_t'(1'b1)); nxt();
    dma_bus.dma_wready = 1'b1;
    obs();
    check("t2_hdr", dma_bus.dma_wdata, hdr(8'h01, 16'd4, 40'h00_0000_1000, 14'h0123));
    check("t2_hdr_rready", w_t'(dma_bus.dma_rready), '0);
    nxt();
    dma_bus.dma_wready = 1'b0;
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      dma_bus.dma_rvalid = pat[i]; dma_bus.dma_rdata = beat(0, i);
      obs();
      check("t2_rready", w_t'(dma_bus.dma_rready), w_t'(1'b1));
      check("t2_rvalid", w_t'(ch_rvalid), pat[i] ? w_t'(4'b0001) : '0);
      if (pat[i]) check("t2_rdata", ch_rdata, beat(0, i));
      nxt();
    end
    dma_bus.dma_rvalid = 1'b0;
    obs();
    check("t2_done", w_t'(ch_done), w_t'(4'b0001));
    check("t2_rready_done", w_t'(dma_bus.dma_rready), '0);
    nxt();
    obs(); check("t2_rready_idle", w_t'(dma_bus.dma_rready), '0); nxt();

    // Fairness: fresh pointer, all channels request len=1 writes continuously.
    reset = 1'b1; nxt(); reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      set_desc(2'(i), 1'b0, 40'(i + 1), 14'(i + 1), 16'd1);
      t_wd[i] = beat(i, 0);
    end
    ch_wvalid = '1; dma_bus.dma_wready = 1'b1; ch_req = '1;
    for (int t = 0; t < 5; t++) begin
      e = 2'(t % 4);
      obs(); nxt();
      obs(); check("t3_grant", w_t'(ch_grant), w_t'(4'b0001 << e)); nxt();
      dma_bus.dma_resp = 1'b1;
      obs(); nxt();
      dma_bus.dma_resp = 1'b0;
      obs(); check("t3_hdr", dma_bus.dma_wdata, hdr(8'h03, 16'd1, 40'(e) + 40'd1, 14'(e) + 14'd1)); nxt();
      obs(); check("t3_data", dma_bus.dma_wdata, beat(int'(e), 0)); nxt();
      obs(); check("t3_done", w_t'(ch_done), w_t'(4'b0001 << e)); nxt();
    end
    ch_req = '0; ch_wvalid = '0;

    // Backpressure: ch2 write len 5 with random wvalid / wready.
    set_desc(2'd2, 1'b0, 40'h55_0000_0000, 14'h0100, 16'd5);
    ch_req = 4'b0100;
    obs(); nxt();
    obs(); check("t4_arb_grant", w_t'(ch_grant), w_t'(4'b0100)); nxt();
    ch_req = '0; dma_bus.dma_resp = 1'b1;
    obs(); nxt();
    dma_bus.dma_resp = 1'b0; dma_bus.dma_wready = 1'b1;
    obs(); check("t4_hdr", dma_bus.dma_wdata, hdr(8'h03, 16'd5, 40'h55_0000_0000, 14'h0100)); nxt();
    k = 0; cyc = 0;
    while (k < 5 && cyc < 200) begin
      wv = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      ch_wvalid = wv ? 4'b0100 : 4'b0000;
      t_wd[2] = beat(2, k);
      dma_bus.dma_wready = wr;
      obs();
      check("t4_wready", w_t'(ch_wready), wr ? w_t'(4'b0100) : '0);
      check("t4_wvalid", w_t'(dma_bus.dma_wvalid), w_t'(wv));
      if (wv && wr) begin
        check("t4_beat", dma_bus.dma_wdata, beat(2, k));
        k++;
      end
      nxt();
      cyc++;
    end
    check("t4_hs_bound", w_t'(k), w_t'(5));
    ch_wvalid = '0; dma_bus.dma_wready = 1'b1;
    obs(); check("t4_done", w_t'(ch_done), w_t'(4'b0100)); nxt();

    // len = 0: header only, then done.
    set_desc(2'd3, 1'b0, 40'hAB_CDEF_0123, 14'h2ABC, 16'd0);
    ch_req = 4'b1000;
    obs(); nxt();
    obs(); check("t5_arb_grant", w_t'(ch_grant), w_t'(4'b1000)); nxt();
    ch_req = '0; dma_bus.dma_resp = 1'b1;
    obs(); nxt();
    dma_bus.dma_resp = 1'b0;
    obs(); check("t5_hdr", dma_bus.dma_wdata, hdr(8'h03, 16'd0, 40'hAB_CDEF_0123, 14'h2ABC)); nxt();
    obs();
    check("t5_done", w_t'(ch_done), w_t'(4'b1000));
    check("t5_wvalid", w_t'(dma_bus.dma_wvalid), '0);
    nxt();

    // Reset in WDATA after 2 of 5 beats.
    set_desc(2'd1, 1'b0, 40'h1, 14'h1, 16'd5);
    ch_req = 4'b0010;
    obs(); nxt();
    obs(); check("t6_arb_grant", w_t'(ch_grant), w_t'(4'b0010)); nxt();
    ch_req = '0; dma_bus.dma_resp = 1'b1;
    obs(); nxt();
    dma_bus.dma_resp = 1'b0;
    obs(); nxt();
    for (int b = 0; b < 2; b++) begin
      ch_wvalid = 4'b0010; t_wd[1] = beat(1, b);
      obs(); check("t6_beat", dma_bus.dma_wdata, beat(1, b)); nxt();
    end
    t_wd[1] = beat(1, 2);
    reset = 1'b1;
    #1;
    check("t6_reset_outs", outs_or(), '0);
    nxt();
    reset = 1'b0; ch_wvalid = '0;
    dseen = '0;
    for (int i = 0; i < 4; i++) begin
      obs(); dseen = dseen | ch_done; nxt();
    end
    check("t6_no_done", w_t'(dseen), '0);

`ifdef DMA_MULTI_CTRL_TIMEOUT_EN
    // Watchdog: path never grants; 16 REQ cycles then an error pulse.
    set_desc(2'd0, 1'b0, 40'h2, 14'h2, 16'd1);
    ch_req = 4'b0001;
    obs(); nxt();
    obs(); nxt();
    ch_req = '0;
    for (int i = 0; i < 16; i++) begin
      obs(); check("to_req", w_t'(dma_bus.dma_req), w_t'(1'b1)); nxt();
    end
    obs();
    check("to_err", w_t'(ch_err), w_t'(4'b0001));
    check("to_no_done", w_t'(ch_done), '0);
    check("to_req_drop", w_t'(dma_bus.dma_req), '0);
    nxt();
    obs(); check("to_idle", outs_or(), '0); nxt();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_multi_ctrl.md
Name: dma_multi_ctrl

Overview:
- Parametrised, multi-channel successor of the single-core DMA controller.
- Arbitrates NUM_CH FPU-core channels round-robin and issues one descriptor header beat per transfer to the DMA path controller.
- For writes, streams LEN payload beats from the granted core; for reads, routes returned beats back to the requesting channel.
- One transfer in flight at a time; adds per-beat valid/ready on every interface.

Parameters:
- NUM_CH, 4: number of core channels (2..8).
- DATA_W, 128: beat width.
- HADDR_W, 40: host address width.
- LADDR_W, 14: local address width.
- LEN_W, 16: transfer length width, in beats.
- Legality: 8+LEN_W+HADDR_W+LADDR_W <= DATA_W. Violation is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ch_req  in  NUM_CH  per-channel transfer request, level.
- ch_rwn  in  NUM_CH  1=read (host to local), 0=write.
- ch_host_addr  in  NUM_CH*HADDR_W  packed, channel i at [i*HADDR_W +: HADDR_W].
- ch_local_addr  in  NUM_CH*LADDR_W  packed.
- ch_len  in  NUM_CH*LEN_W  packed payload beat count.
- ch_grant  out  NUM_CH  one-hot; owner of the current transfer.
- ch_wvalid  in  NUM_CH  write payload valid.
- ch_wdata  in  NUM_CH*DATA_W  packed write payload.
- ch_wready  out  NUM_CH  write payload accepted.
- ch_rvalid  out  NUM_CH  read beat valid; core must accept, no backpressure.
- ch_rdata  out  DATA_W  shared read data.
- ch_done  out  NUM_CH  1-cycle completion pulse.
- ch_err  out  NUM_CH  1-cycle timeout pulse.
- dma_req  out  1  path request.
- dma_resp  in  1  path grant.
- dma_wvalid  out  1  write-stream valid.
- dma_wdata  out  DATA_W  write-stream data.
- dma_wready  in  1  write-stream ready.
- dma_rvalid  in  1  read-stream valid.
- dma_rdata  in  DATA_W  read-stream data.
- dma_rready  out  1  read-stream ready.

Behaviour:
- Reset: all outputs are 0; state IDLE; rr pointer 0; counters 0.
- Reset mid-operation: the in-flight transfer is discarded and no ch_done is issued.
- IDLE: when any ch_req is set, go to ARB.
- ARB (1 cycle):
  - Grant the first requesting channel at or after the rr pointer (wraps NUM_CH-1 to 0).
  - Latch rwn/addr/len into a descriptor register; assert ch_grant; set rr pointer to grant+1 mod NUM_CH.
  - Go to REQ.
  - ch_req or descriptor inputs changing after ARB have no effect.
- REQ: dma_req=1 until dma_resp is sampled high. On that edge dma_req drops and the block goes to HDR. dma_resp in any other state is ignored.
- HDR:
  - dma_wvalid=1.
  - dma_wdata={zero pad, opcode[7:0], len, host_addr, local_addr}, local_addr in the LSBs.
  - opcode is 8'h03 for write, 8'h01 for read.
  - On dma_wvalid&&dma_wready: if len==0 go to DONE; else go to WDATA (write) or RDATA (read).
- WDATA:
  - Combinational pass-through: dma_wvalid=ch_wvalid[g], dma_wdata=ch_wdata[g], ch_wready[g]=dma_wready.
  - Beat counter increments on dma_wvalid&&dma_wready.
  - At count==len-1 with a handshake, go to DONE.
  - Exactly len beats are transferred.
- RDATA:
  - dma_rready=1.
  - ch_rvalid[g]=dma_rvalid and ch_rdata=dma_rdata, combinational with zero latency.
  - Count beats; last beat goes to DONE.
  - Outside RDATA, dma_rready=0.
- DONE (1 cycle): ch_done[g]=1, ch_grant cleared, go to IDLE. A new arbitration is possible the next cycle.
- Non-granted channels always see ch_wready=0 and ch_rvalid=0.
- Counter width is LEN_W. len up to 2^LEN_W-1 is legal.
- Minimum latency from ch_req to header valid: 3 cycles (ARB, REQ with dma_resp in the same cycle, HDR).

Optional Feature:
- Macro: DMA_MULTI_CTRL_TIMEOUT_EN.
- When defined: parameter TIMEOUT_CYC (default 1024) is added.
  - A watchdog counter clears on state entry and on every stream handshake.
  - If it reaches TIMEOUT_CYC in REQ, HDR, WDATA or RDATA, the block drops all valids and dma_req, pulses ch_err[g] in the DONE cycle, and does not pulse ch_done.
- When undefined: no counter exists, ch_err is tied to 0, and stalls wait forever.

Decomposition:
- Package dma_multi_pkg holds:
  - State encoding: IDLE, ARB, REQ, HDR, WDATA, RDATA, DONE.
  - Opcodes OP_WR=8'h03, OP_RD=8'h01.
  - Header field offsets as functions of the widths.
- Sub-module rr_arbiter (NUM_CH): request vector plus pointer in, one-hot grant plus index out, purely combinational. The pointer register stays in dma_multi_ctrl.

Test Plan:
- Single write: ch1 write, len=3, host 0x12_3456_7890, local 0x0040, dma_resp after 2 cycles.
  - Expected: header 0x03_0003_1234567890_0040 packed, then 3 payload beats equal to ch_wdata[1], then ch_done[1] one cycle.
- Read: ch0 read, len=4, dma_rvalid with gaps.
  - Expected: header opcode 0x01, 4 beats on ch_rvalid[0] with matching ch_rdata, dma_rready=0 after DONE.
- Fairness: all 4 channels request continuously, len=1.
  - Expected: grant order 0,1,2,3,0; no channel starved.
- Backpressure: write len=5, with dma_wready toggling and ch_wvalid deasserting randomly.
  - Expected: exactly 5 handshakes and data order preserved.
- Edge cases:
  - len=0: header only, then done.
  - reset asserted in WDATA after 2 of 5 beats: all outputs 0 immediately and no ch_done.
- With DMA_MULTI_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16: dma_resp is never given, so ch_err[g] pulses at cycle 16 of REQ and the block returns to IDLE.
